bit_reader: RTL
===============

# bit_reader

Reader-side companion to the indexed bit-write datapath. The block captures a WIDTH-bit word and returns its bits over a valid/ready output stream. It supports two modes: a single indexed read, or a full scan that emits every bit from index 0 upward. It sits after the bit-write stage, where it lets downstream logic or a bench inspect the modified word one bit at a time.

## Interface
Parameters:
- WIDTH, 4, number of bits in the captured word; power of two, ≥ 2
- IDX_W, $clog2(WIDTH), index width; derived, not overridden

Ports:
- clk  input  1  single clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- load  input  1  capture x into the word register
- x  input  WIDTH  word to capture
- req  input  1  single indexed read request
- index  input  IDX_W  bit position for req
- scan  input  1  start a full scan of all bits
- value  output  1  returned bit
- out_index  output  IDX_W  position of the returned bit
- valid  output  1  value/out_index/last are meaningful
- last  output  1  final bit of a scan; also 1 on a single read
- ready  input  1  consumer accepts the current output
- busy  output  1  block is not in IDLE; load, req and scan are ignored

## Operation
- Word register:
  - word ← x on load, only in IDLE.
  - load while busy is ignored; word is unchanged.
- States: IDLE, HOLD, SCAN.
- IDLE, priority load/scan/req:
  - scan=1: go to SCAN, scan counter cnt←0. Any req in the same cycle is dropped.
  - else req=1: value←word[index], out_index←index, last←1, valid←1, go to HOLD.
  - load is independent of scan/req and updates word the same cycle.
  - A req or scan in the same cycle as load sees the old word. The first scan bit is read the following cycle, so a scan started with load emits the new word.
- HOLD:
  - valid held with stable value/out_index/last until ready=1.
  - On ready: valid←0, last←0, go to IDLE.
- SCAN:
  - value=word[cnt], out_index=cnt, valid=1, last=(cnt==WIDTH-1).
  - On valid&ready: if cnt==WIDTH-1, valid←0, last←0, go to IDLE; else cnt←cnt+1.
  - While ready=0: outputs stable, cnt held.
- busy=1 in HOLD and SCAN, 0 in IDLE.
- Index wrap: cnt never exceeds WIDTH-1. index always addresses a valid bit because WIDTH is a power of two.
- Reset from any state, including mid-scan or HOLD, abandons the operation and emits no further valid.

## Timing
- Reset values: value=0, out_index=0, valid=0, last=0, busy=0, word=0, state=IDLE, cnt=0.
- Single read: req sampled at edge N; valid=1 after edge N; latency 1 cycle. Earliest next req accepted at the edge after the ready handshake completes.
- Scan: scan sampled at edge N; bit 0 valid after edge N+1; with ready held high, one bit per cycle. Bit WIDTH-1 is valid after edge N+WIDTH; IDLE after edge N+WIDTH+1.
- Output changes only on clock edges. valid is never deasserted without ready, except on reset.
- ready is ignored when valid=0.

## Structure
- Shared package bit_pkg:
  - state enum {IDLE, HOLD, SCAN}
  - default WIDTH constant, also used by the write-side block
- Single module; no sub-module required.
- Bit select word[sel] is a plain index mux; the one-hot decode used on the write side is not needed here.

## Test plan
- Reset, then load x=4'b1010; req index=2'b01 with ready=1 → one cycle later valid=1, value=1, out_index=01, last=1; valid=0 next cycle.
- Load x=4'b0110; scan with ready=1 → valid on 4 consecutive cycles with value 0,1,1,0 and out_index 0,1,2,3; last only on index 3; busy falls after.
- Same scan with ready toggled 1,0,0,1,… → each bit held stable while ready=0; no bit skipped or duplicated.
- req and load x=4'b1111 together with word=4'b0000, index=2'b10 → value=0 (old word); a following req at index 2'b10 returns 1.
- scan and req asserted together → scan runs and the req is dropped. load or req asserted during the scan → ignored; word unchanged.
- reset asserted on the cycle out_index=2 during a scan → next cycle valid=0, busy=0, word=0, and no further valid appears.

Source files
------------

// File: rtl/bit_pkg.sv
// Shared definitions for the bit-write / bit-read datapath pair.
// Holds the default word width and the reader state encoding.
package bit_pkg;

    // Default word width, shared with the write-side block
    localparam int WIDTH_DEF = 4;

    // Reader states
    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        SCAN
    } state_t;

endpackage

// File: rtl/bit_reader.sv
// Captures a word and returns its bits over a valid/ready stream,
// either one indexed bit or a full scan from bit 0 upward.
module bit_reader
    import bit_pkg::*;
#(
    parameter  int WIDTH = WIDTH_DEF,
    localparam int IDX_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] x,
    input  logic             req,
    input  logic [IDX_W-1:0] index,
    input  logic             scan,
    output logic             value,
    output logic [IDX_W-1:0] out_index,
    output logic             valid,
    output logic             last,
    input  logic             ready,
    output logic             busy
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] word;
    logic [IDX_W-1:0] cnt;
    logic [IDX_W-1:0] cnt_nx;

    assign cnt_nx = cnt + 1'b1;
    assign busy   = (state != IDLE);

    // Word register: only updated while idle
    always_ff @(posedge clk) begin
        if (reset) begin
            word <= '0;
        end else if (load && state == IDLE) begin
            word <= x;
        end
    end

    // Control FSM with registered stream outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            value     <= 1'b0;
            out_index <= '0;
            valid     <= 1'b0;
            last      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (scan) begin
                        // first bit is fetched next cycle so a
                        // concurrent load is visible to the scan
                        state <= SCAN;
                        cnt   <= '0;
                    end else if (req) begin
                        value     <= word[index];
                        out_index <= index;
                        last      <= 1'b1;
                        valid     <= 1'b1;
                        state     <= HOLD;
                    end
                end
                HOLD: begin
                    if (ready) begin
                        valid <= 1'b0;
                        last  <= 1'b0;
                        state <= IDLE;
                    end
                end
                SCAN: begin
                    if (!valid) begin
                        value     <= word[cnt];
                        out_index <= cnt;
                        last      <= (cnt == LAST_IDX);
                        valid     <= 1'b1;
                    end else if (ready) begin
                        if (cnt == LAST_IDX) begin
                            valid <= 1'b0;
                            last  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            cnt       <= cnt_nx;
                            value     <= word[cnt_nx];
                            out_index <= cnt_nx;
                            last      <= (cnt_nx == LAST_IDX);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
